// File: rtl/sr_ff.sv
// sr_ff -- bank of WIDTH independent clocked set/reset flip-flops.
//
// Each bit takes its next value from S/R on the rising edge of clk. A bit that
// samples S=R=1 is resolved by BOTH_MODE: 0 = hold, 1 = reset wins, 2 = set
// wins. Any other BOTH_MODE value falls back to hold. The state can never
// become undefined.
//
// Ports:
//   clk    in   1      clock; all state updates on its rising edge
//   reset  in   1      asynchronous active-low clear (Q=0, both=0)
//   S      in   WIDTH  per-bit set request
//   R      in   WIDTH  per-bit reset request
//   Q      out  WIDTH  stored state, taken straight from the state register
//   qb     out  WIDTH  ~Q, combinational only
//   both   out  WIDTH  one-cycle flag: the last edge sampled S=R=1 on that bit
module sr_ff #(
  parameter int WIDTH     = 1,
  parameter int BOTH_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] both
);

  // Unsupported mode values collapse to hold.
  localparam int MODE = ((BOTH_MODE == 1) || (BOTH_MODE == 2)) ? BOTH_MODE : 0;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] both_q;
  logic [WIDTH-1:0] both_d;

  always_comb begin
    state_d = state_q;
    both_d  = S & R;
    case (MODE)
      // Reset-dominant: any R clears the bit; S alone sets it.
      1:       state_d = (state_q | (S & ~R)) & ~R;
      // Set-dominant: any S sets the bit; R alone clears it.
      2:       state_d = (state_q | S) & ~(R & ~S);
      // Hold: only an unambiguous request changes the bit.
      default: state_d = (state_q | (S & ~R)) & ~(R & ~S);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      both_q  <= '0;
    end else begin
      state_q <= state_d;
      both_q  <= both_d;
    end
  end

  assign Q    = state_q;
  assign qb   = ~state_q;
  assign both = both_q;

endmodule

// File: tb/tb_sr_ff.sv
// tb_sr_ff -- directed-vector bench for sr_ff.
//
// Four instances share clk and reset:
//   u0: WIDTH=1, BOTH_MODE=0   u1: WIDTH=1, BOTH_MODE=1
//   u2: WIDTH=1, BOTH_MODE=2   u3: WIDTH=4, BOTH_MODE=0
// The stimulus process drives the inputs at t=0,10,20,... At each sample point
// (1 ns after a stimulus change or after a rising edge), it pushes the
// hand-computed expected outputs into a queue and fires an event. A separate
// monitor process pops the queue and compares it against the DUT outputs.
module tb_sr_ff;

  logic       clk = 1'b0;
  logic       reset;
  logic       s0, r0, s1, r1, s2, r2;
  logic [3:0] s3, r3;
  logic       q0, qb0, b0, q1, qb1, b1, q2, qb2, b2;
  logic [3:0] q3, qb3, b3;

  always #5 clk = ~clk;   // first rising edge at t=5

  sr_ff #(.WIDTH(1), .BOTH_MODE(0)) u0 (.clk(clk), .reset(reset), .S(s0), .R(r0), .Q(q0), .qb(qb0), .both(b0));
  sr_ff #(.WIDTH(1), .BOTH_MODE(1)) u1 (.clk(clk), .reset(reset), .S(s1), .R(r1), .Q(q1), .qb(qb1), .both(b1));
  sr_ff #(.WIDTH(1), .BOTH_MODE(2)) u2 (.clk(clk), .reset(reset), .S(s2), .R(r2), .Q(q2), .qb(qb2), .both(b2));
  sr_ff #(.WIDTH(4), .BOTH_MODE(0)) u3 (.clk(clk), .reset(reset), .S(s3), .R(r3), .Q(q3), .qb(qb3), .both(b3));

  typedef struct {
    int         id;
    logic [3:0] q;
    logic [3:0] qb;
    logic [3:0] both;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic expect_v(input int id, input logic [3:0] q, input logic [3:0] qb,
                          input logic [3:0] both, input string name);
    exp_t e;
    e.id = id; e.q = q; e.qb = qb; e.both = both; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    #(t - $time);
  endtask

  // Monitor: drains every pending expectation at each sample event.
  initial begin
    exp_t       e;
    logic [3:0] aq, aqb, ab;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.id)
          0:       begin aq = {3'b000, q0}; aqb = {3'b000, qb0}; ab = {3'b000, b0}; end
          1:       begin aq = {3'b000, q1}; aqb = {3'b000, qb1}; ab = {3'b000, b1}; end
          2:       begin aq = {3'b000, q2}; aqb = {3'b000, qb2}; ab = {3'b000, b2}; end
          default: begin aq = q3;           aqb = qb3;           ab = b3;           end
        endcase
        n_vec++;
        if (aq !== e.q || aqb !== e.qb || ab !== e.both) begin
          n_miss++;
          $display("FAIL %s t=%0t u%0d: got Q=%b qb=%b both=%b, want Q=%b qb=%b both=%b",
                   e.name, $time, e.id, aq, aqb, ab, e.q, e.qb, e.both);
        end else begin
          $display("ok   %s t=%0t u%0d: Q=%b qb=%b both=%b", e.name, $time, e.id, aq, aqb, ab);
        end
      end
    end
  end

  // Watchdog: the run always ends on its own.
  initial begin
    #5000;
    $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // t=0: power-up reset
    reset = 1'b0;
    s0 = 0; r0 = 0; s1 = 0; r1 = 0; s2 = 0; r2 = 0; s3 = 4'b0000; r3 = 4'b0000;
    wait_until(1);
    expect_v(0, 4'h0, 4'h1, 4'h0, "por_async");
    expect_v(3, 4'h0, 4'hF, 4'h0, "por_async_w4");
    -> chk_ev;
    wait_until(6);
    expect_v(0, 4'h0, 4'h1, 4'h0, "por_edge");
    -> chk_ev;

    // t=10: release reset, set u0
    wait_until(10);
    reset = 1'b1; s0 = 1; r0 = 0;
    wait_until(11);
    expect_v(0, 4'h0, 4'h1, 4'h0, "set_before_edge");
    -> chk_ev;
    wait_until(16);
    expect_v(0, 4'h1, 4'h0, 4'h0, "set");
    -> chk_ev;

    // t=20: asynchronous clear mid-operation
    wait_until(20);
    reset = 1'b0; s0 = 0; r0 = 1;
    wait_until(21);
    expect_v(0, 4'h0, 4'h1, 4'h0, "async_clear");
    -> chk_ev;
    wait_until(30);
    s0 = 0; r0 = 0;
    wait_until(36);
    expect_v(0, 4'h0, 4'h1, 4'h0, "held_in_reset");
    -> chk_ev;

    // t=40: release. u0 S=R=1 (hold), u1 set, u2 S=R=1 (set wins), u3 mixed
    wait_until(40);
    reset = 1'b1;
    s0 = 1; r0 = 1;
    s1 = 1; r1 = 0;
    s2 = 1; r2 = 1;
    s3 = 4'b0101; r3 = 4'b0011;
    wait_until(46);
    expect_v(0, 4'h0, 4'h1, 4'h0 | 4'h1, "both_hold_q0");
    expect_v(1, 4'h1, 4'h0, 4'h0, "m1_set");
    expect_v(2, 4'h1, 4'h0, 4'h1, "m2_both_sets");
    expect_v(3, 4'b0100, 4'b1011, 4'b0001, "w4_independent");
    -> chk_ev;

    // t=50
    wait_until(50);
    s0 = 0; r0 = 0;
    s1 = 1; r1 = 1;
    s2 = 0; r2 = 0;
    s3 = 4'b1010; r3 = 4'b0000;
    wait_until(56);
    expect_v(0, 4'h0, 4'h1, 4'h0, "both_drops");
    expect_v(1, 4'h0, 4'h1, 4'h1, "m1_both_clears");
    expect_v(2, 4'h1, 4'h0, 4'h0, "m2_hold");
    expect_v(3, 4'b1110, 4'b0001, 4'b0000, "w4_set_more");
    -> chk_ev;

    // t=60
    wait_until(60);
    s0 = 1; r0 = 0;
    s1 = 0; r1 = 0;
    s2 = 0; r2 = 1;
    s3 = 4'b1111; r3 = 4'b1111;
    wait_until(66);
    expect_v(0, 4'h1, 4'h0, 4'h0, "set_again");
    expect_v(1, 4'h0, 4'h1, 4'h0, "m1_both_drops");
    expect_v(2, 4'h0, 4'h1, 4'h0, "m2_reset");
    expect_v(3, 4'b1110, 4'b0001, 4'b1111, "w4_all_both_hold");
    -> chk_ev;

    // t=70: u0 holds Q=1 under S=R=1 in mode 0
    wait_until(70);
    s0 = 1; r0 = 1;
    s3 = 4'b0000; r3 = 4'b1100;
    wait_until(76);
    expect_v(0, 4'h1, 4'h0, 4'h1, "both_hold_q1");
    expect_v(3, 4'b0010, 4'b1101, 4'b0000, "w4_clear_upper");
    -> chk_ev;

    // t=80
    wait_until(80);
    s0 = 0; r0 = 1;
    s3 = 4'b0000; r3 = 4'b0000;
    s2 = 1; r2 = 0;
    wait_until(86);
    expect_v(0, 4'h0, 4'h1, 4'h0, "reset_bit");
    expect_v(2, 4'h1, 4'h0, 4'h0, "m2_set");
    expect_v(3, 4'b0010, 4'b1101, 4'b0000, "w4_hold");
    -> chk_ev;

    // t=90: async reset discards state everywhere; S held high to show it is ignored
    wait_until(90);
    reset = 1'b0;
    s0 = 1; r0 = 0; s2 = 1; r2 = 1; s3 = 4'b1111; r3 = 4'b1111;
    wait_until(91);
    expect_v(2, 4'h0, 4'h1, 4'h0, "m2_async_clear");
    expect_v(3, 4'h0, 4'hF, 4'h0, "w4_async_clear");
    -> chk_ev;
    wait_until(96);
    expect_v(0, 4'h0, 4'h1, 4'h0, "reset_ignores_s");
    expect_v(3, 4'h0, 4'hF, 4'h0, "w4_reset_ignores_sr");
    -> chk_ev;

    // t=100: release with S=R=0; state stays 0
    wait_until(100);
    reset = 1'b1;
    s0 = 0; r0 = 0; s2 = 0; r2 = 0; s3 = 4'b0000; r3 = 4'b0000;
    wait_until(106);
    expect_v(0, 4'h0, 4'h1, 4'h0, "post_reset_zero");
    expect_v(2, 4'h0, 4'h1, 4'h0, "m2_post_reset_zero");
    -> chk_ev;

    wait_until(110);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
